range_stream_gen: RTL and testbench
===================================

# range_stream_gen

Frame transmitter for the go/data/finish range-tracking protocol: drives the same `go`, `finish` and 4-bit data lines that the range tracker samples. Software or a test harness loads a short list of 4-bit samples into an internal buffer, then pulses `start`; the block plays the list out as one well-formed frame and pulses `done`. It sits upstream of the range tracker inside `my_chip`, fed from `io_in`, and is also the self-test stimulus source for that tracker.

## Interface
- `DEPTH`, 8: sample buffer entries (power of two, ≥2).
- `clock` input 1: single clock, all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `wr_en` input 1: append `wr_data` to buffer (IDLE only).
- `wr_data` input 4: sample to append.
- `clear` input 1: empty the buffer (IDLE only).
- `start` input 1: request one frame transmission.
- `go` output 1: frame-start strobe to tracker.
- `finish` output 1: frame-end strobe to tracker.
- `data_out` output 4: sample to tracker.
- `busy` output 1: frame in progress.
- `done` output 1: one-cycle pulse after the final frame cycle.
- `err` output 1: sticky protocol-misuse flag.
- `count` output $clog2(DEPTH)+1: samples currently buffered.
- `expected_range` output 4: max−min of the last sent frame (see Configuration).

## Operation
- States: IDLE, FIRST, BODY, LAST. All outputs are registered.
- IDLE: `wr_en` with `count<DEPTH` writes `buf[count]` and increments `count`. `wr_en` with `count==DEPTH` drops the data and sets `err`. `clear` zeroes `count` and `err`. If `clear` and `wr_en` arrive together, `clear` wins and the write is dropped.
- `start` in IDLE with `count>0` moves to FIRST. The `wr_en` and `clear` inputs are ignored that cycle.
- `start` in IDLE with `count==0` is ignored and sets `err`.
- Frame length is L = max(count, 2) cycles, indexed k = 0..L−1.
  - `data_out = buf[min(k, count−1)]`.
  - `go=1` only at k=0; `finish=1` only at k=L−1. They are never high together.
  - A single-sample frame therefore sends v0 twice, giving a tracker range of 0.
- FIRST is k=0. BODY covers k=1..L−2 and is skipped when L=2. LAST is k=L−1.
- After LAST the block returns to IDLE; `done=1` for one cycle and `busy=0`.
- Buffer contents and `count` are preserved after a frame, so a new `start` replays the same frame.
- While busy:
  - `wr_en` is ignored and sets `err`.
  - `start` and `clear` are ignored, with no `err`.
- Outside FIRST/BODY/LAST, `data_out` holds its last value and `go`/`finish` are 0.
- Reset values (asynchronous, any time including mid-frame): state IDLE, `count=0`, `go=finish=busy=done=err=0`, `data_out=0`, `expected_range=0`. A frame cut short by reset sends no `finish`.

## Timing
- `start` sampled high at edge t (IDLE, `count>0`):
  - `go`, `busy` and `buf[0]` appear after edge t.
  - `finish` appears after edge t+L−1.
  - `done` appears after edge t+L.
- `start` high in the `done` cycle is accepted, so frames run back-to-back with exactly one idle cycle between `finish` and the next `go`.
- `wr_en` in IDLE is reflected in `count` the next cycle.
- `err` sets the cycle after the offending input and is cleared only by `clear` in IDLE or by reset.

## Configuration
- `RANGE_GEN_EXPECT_EN` defined:
  - Running min and max are tracked over every sample emitted in the frame.
  - `expected_range = max − min`, unsigned 4-bit and never negative, is registered and updates in the `done` cycle.
  - It holds until the next frame's `done`.
- Not defined: `expected_range` is tied to 0 and no min/max registers are built. The port list is unchanged.

## Structure
- The shared package `range_pkg` holds:
  - `data_t` (logic [3:0]);
  - the `gen_state_t` enum {IDLE, FIRST, BODY, LAST};
  - the constant `DATA_W=4`, shared with the tracker.
- Sub-module `range_gen_buf`: DEPTH×4 register array with a write port and a combinational read port, reset to 0.
- The top holds the FSM, the index counter, `count`, `err` and the optional min/max logic.

## Test plan
- Load 3,9,1,6; `start` → `go` with data 3; then 9, 1; `finish` with data 6; `done` next cycle; `expected_range=8` (macro on).
- Load 5 only; `start` → `go`+5, then `finish`+5, total L=2; `expected_range=0`.
- Fill 8 entries, then a 9th `wr_en` → `count` stays 8, `err=1`; `clear` → `count=0`, `err=0`.
- `start` with empty buffer → no `go`, `err=1`. `wr_en` mid-frame → data not stored, `err=1`, frame unaffected.
- Load 2,7, `start`; assert `start` again in the `done` cycle → second `go`+2 exactly one cycle after the first `finish`.
- Drop `reset_n` in BODY → all outputs 0 immediately, `count=0`, no `finish` issued.

Source files
------------

// File: rtl/range_pkg.sv
// Shared types and constants for the range-tracking go/data/finish protocol.
// Used by both the stream generator and the range tracker.
package range_pkg;

  localparam int unsigned DATA_W = 4;

  typedef logic [DATA_W-1:0] data_t;

  // Generator frame states: FIRST is k=0, BODY is k=1..L-2, LAST is k=L-1.
  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    BODY,
    LAST
  } gen_state_t;

endpackage

// File: rtl/range_stream_gen_if.sv
// Host/tracker-facing signal bundle of range_stream_gen.
// master: the generator side. slave: the host loading samples and watching the frame.
interface range_stream_gen_if
  import range_pkg::*;
#(
  parameter int unsigned DEPTH = 8
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             wr_en;
  data_t            wr_data;
  logic             clear;
  logic             start;
  logic             go;
  logic             finish;
  data_t            data_out;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] count;
  data_t            expected_range;

  modport master (
    input  wr_en, wr_data, clear, start,
    output go, finish, data_out, busy, done, err, count, expected_range
  );

  modport slave (
    output wr_en, wr_data, clear, start,
    input  go, finish, data_out, busy, done, err, count, expected_range
  );

endinterface

// File: rtl/range_gen_buf.sv
// Sample buffer for range_stream_gen: DEPTH x DATA_W registers, one write port,
// one combinational read port, cleared on reset.
module range_gen_buf
  import range_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  data_t                    i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output data_t                    o_rd_data
);

  data_t r_mem [DEPTH];

  // Storage array: write one entry per cycle, whole array cleared on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/range_stream_gen.sv
// Frame transmitter for the go/data/finish range-tracking protocol.
// Buffers up to DEPTH samples and plays them out as one frame per start.
// Optional feature macro: RANGE_GEN_EXPECT_EN (builds min/max tracking and
// drives expected_range; otherwise expected_range is tied to 0).
module range_stream_gen
  import range_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  range_stream_gen_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = $clog2(DEPTH);

  gen_state_t       r_state, w_state_d;
  logic [CNT_W-1:0] r_count, w_count_d;
  logic [CNT_W-1:0] r_k, w_k_d;
  logic             r_err, w_err_d;
  logic             r_go, w_go_d;
  logic             r_finish, w_finish_d;
  logic             r_busy, w_busy_d;
  logic             r_done, w_done_d;
  data_t            r_data, w_data_d;

  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_addr;
  logic [IDX_W-1:0] w_rd_addr;
  data_t            w_rd_data;
  logic [CNT_W-1:0] w_k_next;
  logic [CNT_W-1:0] w_rd_k;
  logic [CNT_W-1:0] w_last_k;

  range_gen_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (bus.wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Index of the sample to show next cycle; a single-sample frame repeats the last entry.
  always_comb begin
    w_k_next  = (r_state == IDLE) ? '0 : r_k + CNT_W'(1);
    w_rd_k    = (w_k_next < r_count) ? w_k_next : r_count - CNT_W'(1);
    w_rd_addr = IDX_W'(w_rd_k);
    w_wr_addr = IDX_W'(r_count);
    w_last_k  = (r_count < CNT_W'(2)) ? CNT_W'(1) : r_count - CNT_W'(1);
  end

  // Next-state and registered-output logic for the frame FSM.
  always_comb begin
    w_state_d  = r_state;
    w_count_d  = r_count;
    w_k_d      = r_k;
    w_err_d    = r_err;
    w_go_d     = 1'b0;
    w_finish_d = 1'b0;
    w_busy_d   = r_busy;
    w_done_d   = 1'b0;
    w_data_d   = r_data;
    w_wr_en    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start && (r_count != '0)) begin
          // Accepting a frame masks wr_en/clear for this cycle.
          w_state_d = FIRST;
          w_k_d     = '0;
          w_go_d    = 1'b1;
          w_busy_d  = 1'b1;
          w_data_d  = w_rd_data;
        end else begin
          if (bus.clear) begin
            w_count_d = '0;
            w_err_d   = 1'b0;
          end else if (bus.wr_en) begin
            if (r_count < CNT_W'(DEPTH)) begin
              w_wr_en   = 1'b1;
              w_count_d = r_count + CNT_W'(1);
            end else begin
              w_err_d = 1'b1;
            end
          end
          if (bus.start) begin
            w_err_d = 1'b1;
          end
        end
      end
      FIRST, BODY: begin
        w_k_d    = w_k_next;
        w_data_d = w_rd_data;
        if (w_k_next == w_last_k) begin
          w_state_d  = LAST;
          w_finish_d = 1'b1;
        end else begin
          w_state_d = BODY;
        end
        if (bus.wr_en) begin
          w_err_d = 1'b1;
        end
      end
      LAST: begin
        w_state_d = IDLE;
        w_busy_d  = 1'b0;
        w_done_d  = 1'b1;
        if (bus.wr_en) begin
          w_err_d = 1'b1;
        end
      end
      default: begin
        w_state_d = IDLE;
        w_busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame without a finish.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_k      <= '0;
      r_err    <= 1'b0;
      r_go     <= 1'b0;
      r_finish <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_data   <= '0;
    end else begin
      r_state  <= w_state_d;
      r_count  <= w_count_d;
      r_k      <= w_k_d;
      r_err    <= w_err_d;
      r_go     <= w_go_d;
      r_finish <= w_finish_d;
      r_busy   <= w_busy_d;
      r_done   <= w_done_d;
      r_data   <= w_data_d;
    end
  end

`ifdef RANGE_GEN_EXPECT_EN
  data_t r_min, w_min_d;
  data_t r_max, w_max_d;
  data_t r_range, w_range_d;

  // Running min/max over every emitted sample; range published with done.
  always_comb begin
    w_min_d   = r_min;
    w_max_d   = r_max;
    w_range_d = r_range;
    if ((r_state == IDLE) && (w_state_d == FIRST)) begin
      w_min_d = w_data_d;
      w_max_d = w_data_d;
    end else if ((r_state == FIRST) || (r_state == BODY)) begin
      if (w_data_d < r_min) w_min_d = w_data_d;
      if (w_data_d > r_max) w_max_d = w_data_d;
    end else if (r_state == LAST) begin
      w_range_d = r_max - r_min;
    end
  end

  // Min/max/range registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_min   <= '0;
      r_max   <= '0;
      r_range <= '0;
    end else begin
      r_min   <= w_min_d;
      r_max   <= w_max_d;
      r_range <= w_range_d;
    end
  end

  assign bus.expected_range = r_range;
`else
  assign bus.expected_range = '0;
`endif

  assign bus.go       = r_go;
  assign bus.finish   = r_finish;
  assign bus.data_out = r_data;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.count    = r_count;

endmodule

// File: tb/tb_range_stream_gen.sv
// Self-checking bench for range_stream_gen: a hand-derived vector table, directed
// corner sequences and randomized traffic checked against a frame-level model.
module tb_range_stream_gen;
  import range_pkg::*;

  localparam int unsigned DEPTH = 8;
`ifdef RANGE_GEN_EXPECT_EN
  localparam bit EXP_ON = 1'b1;
`else
  localparam bit EXP_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  range_stream_gen_if #(.DEPTH(DEPTH)) u_if ();

  range_stream_gen #(
    .DEPTH (DEPTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  int n_vec = 0;
  int n_err = 0;

  // One visible output cycle of the reference model.
  typedef struct {
    logic  go;
    logic  finish;
    logic  busy;
    logic  done;
    data_t data;
    data_t rng;
  } rec_t;

  rec_t  m_cur;
  rec_t  m_pend[$];
  data_t m_q[$];
  logic  m_err;
  data_t m_range;

  typedef struct {
    logic  wr;
    data_t wd;
    logic  clr;
    logic  st;
    logic  go;
    logic  fin;
    logic  busy;
    logic  done;
    logic  err;
    data_t data;
    logic [3:0] cnt;
    data_t rng;
  } vec_t;

  vec_t tbl[16];

  function automatic data_t exp_rng(input data_t r);
    return r & {DATA_W{EXP_ON}};
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".go"},     8'(u_if.go),             8'(m_cur.go));
    chk({tag, ".finish"}, 8'(u_if.finish),         8'(m_cur.finish));
    chk({tag, ".busy"},   8'(u_if.busy),           8'(m_cur.busy));
    chk({tag, ".done"},   8'(u_if.done),           8'(m_cur.done));
    chk({tag, ".data"},   8'(u_if.data_out),       8'(m_cur.data));
    chk({tag, ".err"},    8'(u_if.err),            8'(m_err));
    chk({tag, ".count"},  8'(u_if.count),          8'(m_q.size()));
    chk({tag, ".range"},  8'(u_if.expected_range), 8'(exp_rng(m_range)));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pend.delete();
    m_err   = 1'b0;
    m_range = '0;
    m_cur   = '{go: 1'b0, finish: 1'b0, busy: 1'b0, done: 1'b0, data: '0, rng: '0};
  endtask

  // Frame-level model: an accepted start queues the whole frame plus its done cycle.
  task automatic model_step(input logic wr, input data_t wd, input logic clr, input logic st);
    int    n;
    int    len;
    data_t mn;
    data_t mx;
    data_t d;
    if (m_cur.busy) begin
      if (wr) m_err = 1'b1;
    end else if (st && (m_q.size() > 0)) begin
      n   = m_q.size();
      len = (n < 2) ? 2 : n;
      mn  = 4'hf;
      mx  = 4'h0;
      d   = '0;
      for (int k = 0; k < len; k++) begin
        d = m_q[(k < n) ? k : n - 1];
        if (d < mn) mn = d;
        if (d > mx) mx = d;
        m_pend.push_back('{go: (k == 0), finish: (k == len - 1), busy: 1'b1, done: 1'b0,
                           data: d, rng: '0});
      end
      m_pend.push_back('{go: 1'b0, finish: 1'b0, busy: 1'b0, done: 1'b1, data: d,
                         rng: data_t'(mx - mn)});
    end else begin
      if (clr) begin
        m_q.delete();
        m_err = 1'b0;
      end else if (wr) begin
        if (m_q.size() < DEPTH) m_q.push_back(wd);
        else m_err = 1'b1;
      end
      if (st) m_err = 1'b1;
    end
    if (m_pend.size() > 0) begin
      m_cur = m_pend.pop_front();
      if (m_cur.done) m_range = m_cur.rng;
    end else begin
      m_cur.go     = 1'b0;
      m_cur.finish = 1'b0;
      m_cur.busy   = 1'b0;
      m_cur.done   = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model and compare.
  task automatic cyc(input logic wr, input data_t wd, input logic clr, input logic st,
                     input string tag);
    u_if.wr_en   = wr;
    u_if.wr_data = wd;
    u_if.clear   = clr;
    u_if.start   = st;
    @(posedge clock);
    model_step(wr, wd, clr, st);
    #1;
    chk_model(tag);
  endtask

  task automatic do_reset(input string tag);
    u_if.wr_en = 1'b0;
    u_if.clear = 1'b0;
    u_if.start = 1'b0;
    reset_n    = 1'b0;
    model_reset();
    #1;
    chk_model(tag);
    @(posedge clock);
    #1;
    chk({tag, ".finish_held"}, 8'(u_if.finish), 8'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    // wr wd clr st | go fin busy done err data cnt rng
    tbl[0]  = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0};
    tbl[1]  = '{1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 4'd0};
    tbl[2]  = '{1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd0};
    tbl[3]  = '{1'b1, 4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd4, 4'd0};
    tbl[4]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd4, 4'd0};
    tbl[5]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 4'd4, 4'd0};
    tbl[6]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd4, 4'd0};
    tbl[7]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 4'd4, 4'd0};
    tbl[8]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 4'd4, 4'd8};
    tbl[9]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 4'd4, 4'd8};
    tbl[10] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd4, 4'd8};
    tbl[11] = '{1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 4'd4, 4'd8};
    tbl[12] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 4'd4, 4'd8};
    tbl[13] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 4'd4, 4'd8};
    tbl[14] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 4'd4, 4'd8};
    tbl[15] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0, 4'd8};

    reset_n      = 1'b0;
    u_if.wr_en   = 1'b0;
    u_if.wr_data = '0;
    u_if.clear   = 1'b0;
    u_if.start   = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk_model("reset");
    reset_n = 1'b1;

    // Table: load 3,9,1,6 and send; replay with a mid-frame write; clear.
    for (int i = 0; i < 16; i++) begin
      u_if.wr_en   = tbl[i].wr;
      u_if.wr_data = tbl[i].wd;
      u_if.clear   = tbl[i].clr;
      u_if.start   = tbl[i].st;
      @(posedge clock);
      model_step(tbl[i].wr, tbl[i].wd, tbl[i].clr, tbl[i].st);
      #1;
      chk($sformatf("tbl%0d.go", i),    8'(u_if.go),             8'(tbl[i].go));
      chk($sformatf("tbl%0d.fin", i),   8'(u_if.finish),         8'(tbl[i].fin));
      chk($sformatf("tbl%0d.busy", i),  8'(u_if.busy),           8'(tbl[i].busy));
      chk($sformatf("tbl%0d.done", i),  8'(u_if.done),           8'(tbl[i].done));
      chk($sformatf("tbl%0d.err", i),   8'(u_if.err),            8'(tbl[i].err));
      chk($sformatf("tbl%0d.data", i),  8'(u_if.data_out),       8'(tbl[i].data));
      chk($sformatf("tbl%0d.count", i), 8'(u_if.count),          8'(tbl[i].cnt));
      chk($sformatf("tbl%0d.range", i), 8'(u_if.expected_range), 8'(exp_rng(tbl[i].rng)));
    end

    // Single sample: v0 sent twice, range 0.
    cyc(1'b0, 4'd0, 1'b1, 1'b0, "single.clr");
    cyc(1'b1, 4'd5, 1'b0, 1'b0, "single.wr");
    cyc(1'b0, 4'd0, 1'b0, 1'b1, "single.go");
    chk("single.go_data", {u_if.go, 3'd0, u_if.data_out}, {1'b1, 3'd0, 4'd5});
    cyc(1'b0, 4'd0, 1'b0, 1'b0, "single.fin");
    chk("single.fin_data", {u_if.go, u_if.finish, 2'd0, u_if.data_out}, {2'b01, 2'd0, 4'd5});
    cyc(1'b0, 4'd0, 1'b0, 1'b0, "single.done");
    chk("single.done", 8'(u_if.done), 8'd1);
    chk("single.range", 8'(u_if.expected_range), 8'd0);

    // Overflow: ninth write dropped and flagged; clear recovers.
    cyc(1'b0, 4'd0, 1'b1, 1'b0, "ovf.clr");
    for (int i = 0; i < int'(DEPTH); i++) cyc(1'b1, data_t'(i + 2), 1'b0, 1'b0, "ovf.fill");
    cyc(1'b1, 4'd12, 1'b0, 1'b0, "ovf.ninth");
    chk("ovf.count", 8'(u_if.count), 8'd8);
    chk("ovf.err", 8'(u_if.err), 8'd1);
    cyc(1'b0, 4'd0, 1'b1, 1'b0, "ovf.clear");
    chk("ovf.count_clr", 8'(u_if.count), 8'd0);
    chk("ovf.err_clr", 8'(u_if.err), 8'd0);

    // Start with empty buffer.
    cyc(1'b0, 4'd0, 1'b0, 1'b1, "empty.start");
    chk("empty.go", 8'(u_if.go), 8'd0);
    chk("empty.err", 8'(u_if.err), 8'd1);
    cyc(1'b0, 4'd0, 1'b1, 1'b0, "empty.clr");

    // Back-to-back: start in the done cycle gives one idle cycle after finish.
    cyc(1'b1, 4'd2, 1'b0, 1'b0, "b2b.wr2");
    cyc(1'b1, 4'd7, 1'b0, 1'b0, "b2b.wr7");
    cyc(1'b0, 4'd0, 1'b0, 1'b1, "b2b.go1");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, "b2b.fin1");
    chk("b2b.fin1", {u_if.finish, 3'd0, u_if.data_out}, {1'b1, 3'd0, 4'd7});
    cyc(1'b0, 4'd0, 1'b0, 1'b0, "b2b.done1");
    chk("b2b.done1", {u_if.done, u_if.go, 6'd0}, {2'b10, 6'd0});
    cyc(1'b0, 4'd0, 1'b0, 1'b1, "b2b.go2");
    chk("b2b.go2", {u_if.go, 3'd0, u_if.data_out}, {1'b1, 3'd0, 4'd2});
    cyc(1'b0, 4'd0, 1'b0, 1'b0, "b2b.fin2");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, "b2b.done2");

    // Reset in BODY: everything drops at once, no finish.
    cyc(1'b0, 4'd0, 1'b1, 1'b0, "rst.clr");
    cyc(1'b1, 4'd4, 1'b0, 1'b0, "rst.wr");
    cyc(1'b1, 4'd8, 1'b0, 1'b0, "rst.wr");
    cyc(1'b1, 4'd12, 1'b0, 1'b0, "rst.wr");
    cyc(1'b0, 4'd0, 1'b0, 1'b1, "rst.go");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, "rst.body");
    chk("rst.body_data", 8'(u_if.data_out), 8'd8);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst.outs", {u_if.go, u_if.finish, u_if.busy, u_if.done, u_if.err, 3'd0}, 8'd0);
    chk("rst.data", 8'(u_if.data_out), 8'd0);
    chk("rst.count", 8'(u_if.count), 8'd0);
    chk("rst.range", 8'(u_if.expected_range), 8'd0);
    model_reset();
    repeat (3) begin
      @(posedge clock);
      #1;
      chk("rst.no_finish", 8'(u_if.finish), 8'd0);
    end
    reset_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(999));
      if (r < 2) begin
        do_reset("rand.reset");
      end else begin
        r = r % 100;
        cyc(r < 30, data_t'($urandom), (r >= 30) && (r < 35), (r >= 35) && (r < 47), "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
